// File: rtl/esp_pkt_framer_if.sv
// Byte-stream interface for the ESP32 UART packet framer.
// Carries the payload write port, the frame control signals and the transmitter handshake.
interface esp_pkt_framer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       send;
  logic       busy;
  logic       pkt_done;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport slave (
    input  in_data, in_valid, send, tx_ready,
    output in_ready, busy, pkt_done, tx_data, tx_valid
  );

  modport master (
    output in_data, in_valid, send, tx_ready,
    input  in_ready, busy, pkt_done, tx_data, tx_valid
  );
endinterface

// File: rtl/esp_pkt_framer.sv
// Packet framer ahead of the ESP32 UART transmitter: buffers payload bytes in a FIFO,
// then on send emits SOF, LEN, payload and an 8-bit wrapping checksum over valid/ready.
module esp_pkt_framer #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] SOF   = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  esp_pkt_framer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_LEN,
    S_PAY,
    S_CSUM
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_nxt;
  logic [CW-1:0]   count;
  logic [7:0]      len;
  logic [7:0]      csum;
  logic [7:0]      pay_left;
  logic [7:0]      tx_data_r;
  logic            tx_valid_r;
  logic            pkt_done_r;
  logic            full;
  logic            in_rdy;
  logic            wr_en;
  logic            tx_fire;
  logic            pop;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign in_rdy  = (state == S_IDLE) && !full && !bus.send;
  assign wr_en   = bus.in_valid && in_rdy;
  assign tx_fire = tx_valid_r && bus.tx_ready;
  assign pop     = (state == S_PAY) && tx_fire;
  assign rd_nxt  = rd_ptr + AW'(1);

  assign bus.in_ready = in_rdy;
  assign bus.busy     = (state != S_IDLE);
  assign bus.pkt_done = pkt_done_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.tx_valid = tx_valid_r;

  // Payload storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_nxt;
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer; each state's byte is loaded on entry so tx_valid is up immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      len        <= 8'h00;
      csum       <= 8'h00;
      pay_left   <= 8'h00;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      pkt_done_r <= 1'b0;
    end else begin
      pkt_done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.send && (count != '0)) begin
            state      <= S_SOF;
            len        <= 8'(count);
            csum       <= 8'h00;
            tx_data_r  <= SOF;
            tx_valid_r <= 1'b1;
          end
        end
        S_SOF: begin
          if (tx_fire) begin
            state     <= S_LEN;
            tx_data_r <= len;
          end
        end
        S_LEN: begin
          if (tx_fire) begin
            state     <= S_PAY;
            csum      <= csum_add(csum, len);
            pay_left  <= len;
            tx_data_r <= mem[rd_ptr];
          end
        end
        S_PAY: begin
          if (tx_fire) begin
            csum     <= csum_add(csum, tx_data_r);
            pay_left <= pay_left - 8'd1;
            // Last payload byte: the checksum byte is the running sum including it
            if (pay_left == 8'd1) begin
              state     <= S_CSUM;
              tx_data_r <= csum_add(csum, tx_data_r);
            end else begin
              tx_data_r <= mem[rd_nxt];
            end
          end
        end
        S_CSUM: begin
          if (tx_fire) begin
            state      <= S_IDLE;
            tx_valid_r <= 1'b0;
            pkt_done_r <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          tx_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_esp_pkt_framer.sv
// Directed bench for esp_pkt_framer: frame contents, back-pressure, FIFO full, reset abort.
module tb_esp_pkt_framer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  esp_pkt_framer_if bus();

  esp_pkt_framer #(.DEPTH(16), .SOF(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Entered and left on a negedge
  task automatic wr(input logic [7:0] b, input logic exp_rdy);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    #1 check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_send(input logic exp_start);
    bus.send = 1'b1;
    #1 check("in_ready_on_send", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    bus.send = 1'b0;
    if (exp_start) begin
      check("sof_latency_valid", {31'd0, bus.tx_valid}, 32'd1);
      check("sof_latency_busy", {31'd0, bus.busy}, 32'd1);
    end else begin
      check("ignored_send_valid", {31'd0, bus.tx_valid}, 32'd0);
      check("ignored_send_busy", {31'd0, bus.busy}, 32'd0);
    end
  endtask

  // Drains one frame against exp_q; tx_ready decided at each negedge for the next posedge
  task automatic run_frame(input logic rnd, input string tag);
    int         idx = 0;
    int         cyc = 0;
    logic       stalled = 1'b0;
    logic [7:0] held = 8'h00;
    logic       rdy;
    while (idx < exp_q.size() && cyc < 400) begin
      if (stalled)
        check({tag, " stall_hold"}, {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, held});
      check({tag, " no_early_done"}, {31'd0, bus.pkt_done}, 32'd0);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.tx_ready = rdy;
      if (bus.tx_valid && rdy) begin
        check({tag, " byte"}, {24'd0, bus.tx_data}, {24'd0, exp_q[idx]});
        idx++;
      end
      stalled = bus.tx_valid && !rdy;
      held    = bus.tx_data;
      @(negedge clk);
      cyc++;
    end
    bus.tx_ready = 1'b0;
    check({tag, " complete"}, idx, exp_q.size());
    check({tag, " pkt_done"}, {31'd0, bus.pkt_done}, 32'd1);
    check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " valid_at_done"}, {31'd0, bus.tx_valid}, 32'd0);
    @(negedge clk);
    check({tag, " pkt_done_pulse"}, {31'd0, bus.pkt_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.send     = 1'b0;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'h00);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_pkt_done", {31'd0, bus.pkt_done}, 32'd0);
    rst = 1'b1;
    #1 check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);

    // Basic frame
    wr(8'hA1, 1'b1);
    wr(8'hB2, 1'b1);
    wr(8'hC3, 1'b1);
    do_send(1'b1);
    exp_q = '{8'hA5, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h19};
    run_frame(1'b0, "t1");

    // Send with empty FIFO
    do_send(1'b0);
    repeat (3) begin
      @(negedge clk);
      check("t2 tx_valid", {31'd0, bus.tx_valid}, 32'd0);
      check("t2 busy", {31'd0, bus.busy}, 32'd0);
      check("t2 pkt_done", {31'd0, bus.pkt_done}, 32'd0);
    end

    // Random back-pressure
    wr(8'hA1, 1'b1);
    wr(8'hB2, 1'b1);
    wr(8'hC3, 1'b1);
    do_send(1'b1);
    exp_q = '{8'hA5, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h19};
    run_frame(1'b1, "t3");

    // Fill to full; 17th byte refused
    for (int i = 0; i < 17; i++) wr(8'(i), (i < 16) ? 1'b1 : 1'b0);
    do_send(1'b1);
    exp_q = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h88);
    run_frame(1'b0, "t4");

    // Write in the send cycle is refused
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    bus.send     = 1'b1;
    #1 check("t6 in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    bus.send     = 1'b0;
    bus.in_valid = 1'b0;
    check("t6 sof_valid", {31'd0, bus.tx_valid}, 32'd1);
    exp_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h35};
    run_frame(1'b0, "t6");
    do_send(1'b0);
    @(negedge clk);

    // Reset mid-payload
    wr(8'hA1, 1'b1);
    wr(8'hB2, 1'b1);
    wr(8'hC3, 1'b1);
    do_send(1'b1);
    bus.tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.tx_ready = 1'b0;
    check("t5 in_pay_data", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, 8'hA1});
    #2 rst = 1'b0;
    #1;
    check("t5 rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("t5 rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5 in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    check("t5 no_pkt_done", {31'd0, bus.pkt_done}, 32'd0);
    @(negedge clk);
    wr(8'h55, 1'b1);
    do_send(1'b1);
    exp_q = '{8'hA5, 8'h01, 8'h55, 8'h56};
    run_frame(1'b0, "t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
